// File: rtl/wshb_rr_arbiter.sv
// wshb_rr_arbiter: N-master Wishbone arbiter in front of a single slave port.
// Ownership is round-robin and lasts for the owner's whole cyc. The request
// and response paths are combinational through the registered grant. An
// optional watchdog ends stalled strobes with a one-cycle err to the owner.
module wshb_rr_arbiter #(
  parameter int NM         = 2,
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [NM-1:0]              m_cyc,
  input  logic [NM-1:0]              m_stb,
  input  logic [NM-1:0]              m_we,
  input  logic [NM*ADDR_W-1:0]       m_adr,
  input  logic [NM*8*DATA_BYTES-1:0] m_dat_ms,
  input  logic [NM*DATA_BYTES-1:0]   m_sel,
  input  logic [NM*3-1:0]            m_cti,
  input  logic [NM*2-1:0]            m_bte,
  output logic [NM-1:0]              m_ack,
  output logic [NM-1:0]              m_err,
  output logic [NM-1:0]              m_rty,
  output logic [8*DATA_BYTES-1:0]    m_dat_sm,
  output logic                       s_cyc,
  output logic                       s_stb,
  output logic                       s_we,
  output logic [ADDR_W-1:0]          s_adr,
  output logic [8*DATA_BYTES-1:0]    s_dat_ms,
  output logic [DATA_BYTES-1:0]      s_sel,
  output logic [2:0]                 s_cti,
  output logic [1:0]                 s_bte,
  input  logic                       s_ack,
  input  logic                       s_err,
  input  logic                       s_rty,
  input  logic [8*DATA_BYTES-1:0]    s_dat_sm,
  output logic [NM-1:0]              grant,
  output logic                       busy
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  logic [NM-1:0] grant_r;
  logic          busy_r;
  logic [PW-1:0] ptr_r;

  logic          owner_cyc_s;
  logic          owner_stb_s;
  logic          term_s;
  logic          stall_s;
  logic          timeout_s;
  logic          arb_en_s;
  logic          pick_found_s;
  logic [PW-1:0] pick_idx_s;
  logic [PW-1:0] pick_next_s;
  logic [PW-1:0] scan_idx_s;
  logic [NM-1:0] pick_grant_s;

  assign owner_cyc_s = |(grant_r & m_cyc);
  assign owner_stb_s = |(grant_r & m_stb);
  assign term_s      = s_ack | s_err | s_rty;
  assign stall_s     = owner_cyc_s & owner_stb_s & ~term_s;
  // Re-arbitrate when idle or when the owner has released cyc.
  assign arb_en_s    = ~owner_cyc_s;

  // Round-robin scan: first requester at or after the pointer, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {PW{1'b0}};
    scan_idx_s   = {PW{1'b0}};
    for (int j = 0; j < NM; j++) begin
      scan_idx_s = PW'((int'(ptr_r) + j) % NM);
      if (!pick_found_s && m_cyc[scan_idx_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = scan_idx_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // One-hot grant for the winner and the pointer just past it.
  always_comb begin
    pick_grant_s = {NM{1'b0}};
    if (pick_found_s) begin
      pick_grant_s[pick_idx_s] = 1'b1;
    end else begin
      pick_grant_s = {NM{1'b0}};
    end
    if (pick_idx_s == PW'(NM - 1)) begin
      pick_next_s = {PW{1'b0}};
    end else begin
      pick_next_s = pick_idx_s + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Grant/pointer register: ownership changes only when the owner drops cyc.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      grant_r <= {NM{1'b0}};
      busy_r  <= 1'b0;
      ptr_r   <= {PW{1'b0}};
    end else if (arb_en_s) begin
      grant_r <= pick_grant_s;
      busy_r  <= pick_found_s;
      if (pick_found_s) begin
        ptr_r <= pick_next_s;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
      logic [CW-1:0] wd_cnt_r;

      // Fires in the TIMEOUT-th consecutive stalled cycle; slave termination wins.
      assign timeout_s = stall_s & (wd_cnt_r == CW'(TIMEOUT - 1));

      // Stall counter: counts unanswered strobes, clears on any termination or handover.
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          wd_cnt_r <= {CW{1'b0}};
        end else if (arb_en_s || timeout_s || term_s) begin
          wd_cnt_r <= {CW{1'b0}};
        end else if (stall_s) begin
          wd_cnt_r <= wd_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end else begin : g_no_wd
      assign timeout_s = 1'b0;
    end
  endgenerate

  // Request mux: one-hot grant selects the owner's signals, zeros when idle.
  always_comb begin
    s_we     = 1'b0;
    s_adr    = {ADDR_W{1'b0}};
    s_dat_ms = {DW{1'b0}};
    s_sel    = {DATA_BYTES{1'b0}};
    s_cti    = 3'b000;
    s_bte    = 2'b00;
    for (int i = 0; i < NM; i++) begin
      s_we     = s_we     | (m_we[i] & grant_r[i]);
      s_adr    = s_adr    | (m_adr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_r[i]}});
      s_dat_ms = s_dat_ms | (m_dat_ms[i*DW +: DW] & {DW{grant_r[i]}});
      s_sel    = s_sel    | (m_sel[i*DATA_BYTES +: DATA_BYTES] & {DATA_BYTES{grant_r[i]}});
      s_cti    = s_cti    | (m_cti[i*3 +: 3] & {3{grant_r[i]}});
      s_bte    = s_bte    | (m_bte[i*2 +: 2] & {2{grant_r[i]}});
    end
  end

  // A watchdog expiry withdraws the cycle from the slave for that one cycle.
  assign s_cyc    = owner_cyc_s & ~timeout_s;
  assign s_stb    = owner_stb_s & ~timeout_s;

  assign m_ack    = grant_r & {NM{s_ack}};
  assign m_err    = grant_r & {NM{s_err | timeout_s}};
  assign m_rty    = grant_r & {NM{s_rty}};
  assign m_dat_sm = s_dat_sm;

  assign grant    = grant_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Randomised bench for wshb_rr_arbiter (3 masters, watchdog of 8 cycles).
// A stimulus process drives masters/slave and pushes the expected outputs
// from a reference model; a monitor pops and compares on the falling edge.
module tb_wshb_rr_arbiter;

  localparam int NM   = 3;
  localparam int DB   = 4;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int TO   = 8;
  localparam int NCYC = 4000;

  logic              sys_clk;
  logic              sys_rst;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat_ms;
  logic [NM*DB-1:0]  m_sel;
  logic [NM*3-1:0]   m_cti;
  logic [NM*2-1:0]   m_bte;
  logic [NM-1:0]     m_ack, m_err, m_rty;
  logic [DW-1:0]     m_dat_sm;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_ms;
  logic [DB-1:0]     s_sel;
  logic [2:0]        s_cti;
  logic [1:0]        s_bte;
  logic              s_ack, s_err, s_rty;
  logic [DW-1:0]     s_dat_sm;
  logic [NM-1:0]     grant;
  logic              busy;

  wshb_rr_arbiter #(.NM(NM), .DATA_BYTES(DB), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
    .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_sm(m_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
    .grant(grant), .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          cyc;
    logic [2:0]  grant;
    logic        busy, s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_ms, m_dat_sm;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [2:0]  m_ack, m_err, m_rty;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc_no = 0;

  // Reference model state: current owner (-1 = nobody), next-to-serve pointer,
  // and number of consecutive unanswered strobe cycles of the owner.
  int own = -1;
  int ptr = 0;
  int stalled = 0;
  int hold[NM];

  function automatic bit bit_of(logic [NM-1:0] v, int i);
    return ((v >> i) & 3'b001) != 3'b000;
  endfunction

  function automatic logic [2:0] onehot(int i);
    return 3'(1 << i);
  endfunction

  // Does the owner's current strobe hit the watchdog this cycle?
  function automatic bit wd_fires();
    bit busy_stb;
    if (own < 0) return 1'b0;
    busy_stb = bit_of(m_cyc, own) && bit_of(m_stb, own) && !(s_ack || s_err || s_rty);
    return busy_stb && (stalled + 1 == TO);
  endfunction

  // Ownership and stall bookkeeping at a rising edge.
  task automatic model_edge();
    int winner;
    bit term, busy_stb;
    if (sys_rst) begin
      own = -1; ptr = 0; stalled = 0;
    end else if (own < 0 || !bit_of(m_cyc, own)) begin
      winner = -1;
      for (int k = 0; k < NM; k++) begin
        if (winner < 0 && bit_of(m_cyc, (ptr + k) % NM)) winner = (ptr + k) % NM;
      end
      own = winner;
      if (winner >= 0) ptr = (winner + 1) % NM;
      stalled = 0;
    end else begin
      term     = s_ack || s_err || s_rty;
      busy_stb = bit_of(m_cyc, own) && bit_of(m_stb, own) && !term;
      if (wd_fires() || term) stalled = 0;
      else if (busy_stb) stalled = stalled + 1;
    end
  endtask

  // Expected DUT outputs for the inputs now applied.
  function automatic exp_t model_outputs();
    exp_t e;
    bit   to;
    e = '{default: 0};
    e.cyc      = cyc_no;
    e.m_dat_sm = s_dat_sm;
    if (own >= 0) begin
      to         = wd_fires();
      e.grant    = onehot(own);
      e.busy     = 1'b1;
      e.s_cyc    = bit_of(m_cyc, own) && !to;
      e.s_stb    = bit_of(m_stb, own) && !to;
      e.s_we     = bit_of(m_we, own);
      e.s_adr    = 32'(m_adr >> (own * AW));
      e.s_dat_ms = 32'(m_dat_ms >> (own * DW));
      e.s_sel    = 4'(m_sel >> (own * DB));
      e.s_cti    = 3'(m_cti >> (own * 3));
      e.s_bte    = 2'(m_bte >> (own * 2));
      e.m_ack    = s_ack ? onehot(own) : 3'b000;
      e.m_err    = (s_err || to) ? onehot(own) : 3'b000;
      e.m_rty    = s_rty ? onehot(own) : 3'b000;
    end
    return e;
  endfunction

  task automatic chk(string nm, int cyc, logic [63:0] act, logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(int c);
    bit silent;
    int r;
    silent  = ((c / 250) % 3) == 2;
    sys_rst = (c < 3) || (c == 1500) || ($urandom_range(0, 299) == 0);
    if (c == 1500) begin
      for (int i = 0; i < NM; i++) hold[i] = 10;
    end
    for (int i = 0; i < NM; i++) begin
      if (hold[i] > 0) begin
        m_cyc[i] = 1'b1;
        m_stb[i] = silent ? 1'b1 : ($urandom_range(0, 3) != 0);
        hold[i]  = hold[i] - 1;
      end else begin
        m_cyc[i] = 1'b0;
        m_stb[i] = 1'b0;
        if ($urandom_range(0, 2) == 0)
          hold[i] = silent ? $urandom_range(5, 30) : $urandom_range(1, 16);
      end
      m_we[i]               = 1'($urandom());
      m_adr[i*AW +: AW]     = $urandom();
      m_dat_ms[i*DW +: DW]  = $urandom();
      m_sel[i*DB +: DB]     = 4'($urandom());
      m_cti[i*3 +: 3]       = 3'($urandom());
      m_bte[i*2 +: 2]       = 2'($urandom());
    end
    r = $urandom_range(0, 99);
    s_ack    = silent ? (r < 3) : (r < 40);
    s_err    = !silent && (r >= 40) && (r < 45);
    s_rty    = !silent && (r >= 45) && (r < 50);
    s_dat_sm = $urandom();
  endtask

  // Stimulus: advance the model at each edge, drive new inputs, queue expectations.
  initial begin
    sys_rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_ms = '0;
    m_sel = '0; m_cti = '0; m_bte = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_sm = '0;
    for (int i = 0; i < NM; i++) hold[i] = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge sys_clk);
      model_edge();
      #1;
      cyc_no = c;
      drive(c);
      sb_q.push_back(model_outputs());
    end
    @(posedge sys_clk);
    #1;
    chk("scoreboard_drained", NCYC, 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Monitor: compare DUT outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("grant",    e.cyc, 64'(grant),    64'(e.grant));
        chk("busy",     e.cyc, 64'(busy),     64'(e.busy));
        chk("s_cyc",    e.cyc, 64'(s_cyc),    64'(e.s_cyc));
        chk("s_stb",    e.cyc, 64'(s_stb),    64'(e.s_stb));
        chk("s_we",     e.cyc, 64'(s_we),     64'(e.s_we));
        chk("s_adr",    e.cyc, 64'(s_adr),    64'(e.s_adr));
        chk("s_dat_ms", e.cyc, 64'(s_dat_ms), 64'(e.s_dat_ms));
        chk("s_sel",    e.cyc, 64'(s_sel),    64'(e.s_sel));
        chk("s_cti",    e.cyc, 64'(s_cti),    64'(e.s_cti));
        chk("s_bte",    e.cyc, 64'(s_bte),    64'(e.s_bte));
        chk("m_ack",    e.cyc, 64'(m_ack),    64'(e.m_ack));
        chk("m_err",    e.cyc, 64'(m_err),    64'(e.m_err));
        chk("m_rty",    e.cyc, 64'(m_rty),    64'(e.m_rty));
        chk("m_dat_sm", e.cyc, 64'(m_dat_sm), 64'(e.m_dat_sm));
      end
    end
  end

endmodule
